// File: rtl/alu_mul_div.sv
// Iterative multiply/divide unit with architectural HI/LO registers and a busy/done handshake.
// Define MULDIV_FAST_MULT_EN to compute MULT/MULTU in a single cycle; divides stay iterative.
module alu_mul_div #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        hiWrite,
    input  logic        loWrite,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

    state_e      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;      // product, or {remainder, quotient} while dividing
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] ymag_q, ymag_d;    // multiplier (shifted out) or divisor (held)
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signed_op, sx, sy;
    logic [31:0] x_mag, y_mag;
    logic [32:0] shl_hi, trial;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign signed_op = ~op[0];
    assign sx        = signed_op & x[31];
    assign sy        = signed_op & y[31];
    assign x_mag     = sx ? -x : x;
    assign y_mag     = sy ? -y : y;

    // Restoring step: shift {rem, quo} left one bit and try subtracting the divisor.
    assign shl_hi    = acc_q[63:31];
    assign trial     = shl_hi - {1'b0, ymag_q};

    assign prod_fix  = neg_q     ? -acc_q        : acc_q;
    assign quo_fix   = neg_q     ? -acc_q[31:0]  : acc_q[31:0];
    assign rem_fix   = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'b0, x_mag} * {32'b0, y_mag};
`endif

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through this block infers a latch.
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        ymag_d    = ymag_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_d     = sx ^ sy;
                    rem_neg_d = sx;
                    dz_d      = op[1] & (y == 32'd0);
                    ymag_d    = y_mag;
                    mcand_d   = {32'b0, x_mag};
                    acc_d     = op[1] ? {32'b0, x_mag} : 64'd0;
                    count_d   = 6'd0;
                    state_d   = S_RUN;
`ifdef MULDIV_FAST_MULT_EN
                    if (!op[1]) begin
                        acc_d   = fast_prod;
                        state_d = S_FINISH;
                    end
`endif
                end else begin
                    if (hiWrite) hi_d = x;
                    if (loWrite) lo_d = x;
                end
            end
            S_RUN: begin
                count_d = count_q + 6'd1;
                if (is_div_q) begin
                    if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
                    else            acc_d = {acc_q[62:0], 1'b0};
                end else begin
                    if (ymag_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d = mcand_q << 1;
                    ymag_d  = ymag_q >> 1;
                end
                if (count_q == 6'(ITER - 1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                if (is_div_q) begin
                    lo_d = dz_q ? 32'hFFFF_FFFF : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= 6'd0;
            acc_q     <= 64'd0;
            mcand_q   <= 64'd0;
            ymag_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            ymag_q    <= ymag_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
